// File: rtl/sw_array_sequencer_if.sv
// Stream, array-drive and score signals of sw_array_sequencer.
// slave is the sequencer's view; master is the upstream/array side.
interface sw_array_sequencer_if #(
   parameter int WIDTH = 10,
   parameter int LEN_W = 16
);
   logic [1:0]       q_base;
   logic             q_valid;
   logic             q_ready;
   logic [1:0]       r_base;
   logic             r_valid;
   logic             r_ready;
   logic [LEN_W-1:0] ref_len;
   logic [1:0]       arr_S;
   logic             arr_shift_S;
   logic             arr_store_S;
   logic [1:0]       arr_T;
   logic             arr_init;
   logic [WIDTH-1:0] arr_V;
   logic [WIDTH-1:0] score;
   logic             score_valid;
   logic             score_err;
   logic             busy;

   modport slave (
      input  q_base, q_valid, r_base, r_valid, ref_len, arr_V,
      output q_ready, r_ready, arr_S, arr_shift_S, arr_store_S, arr_T, arr_init,
             score, score_valid, score_err, busy
   );

   modport master (
      output q_base, q_valid, r_base, r_valid, ref_len, arr_V,
      input  q_ready, r_ready, arr_S, arr_shift_S, arr_store_S, arr_T, arr_init,
             score, score_valid, score_err, busy
   );
endinterface

// File: rtl/sw_array_sequencer.sv
// Sequences a Smith-Waterman systolic array: loads queries, streams references with an
// aligned store strobe, and collects the per-iteration max score through a delay line.
module sw_array_sequencer #(
   parameter int NUM_PES = 10,
   parameter int WIDTH   = 10,
   parameter int LEN_W   = 16
) (
   input logic                 clk,
   input logic                 rst,
   sw_array_sequencer_if.slave bus
);
   localparam int QCW = $clog2(NUM_PES + 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_STREAM = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;

   localparam logic [QCW-1:0]   QCNT_FULL = QCW'(NUM_PES);
   localparam logic [QCW-1:0]   QCNT_ONE  = QCW'(1);
   localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

   logic [1:0]         state_q, state_d;
   logic [QCW-1:0]     qcnt_q, qcnt_d;
   logic [LEN_W-1:0]   rcnt_q, rcnt_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               err_q, err_d;
   logic [NUM_PES-1:0] dl_init_q, dl_init_d;
   logic [NUM_PES-1:0] dl_last_q, dl_last_d;
   logic [NUM_PES-1:0] dl_err_q, dl_err_d;
   logic [WIDTH-1:0]   max_q, max_d;
   logic [WIDTH-1:0]   score_q, score_d;
   logic               score_valid_q, score_valid_d;
   logic               score_err_q, score_err_d;

   logic               qfull, stream_open, stream_done;
   logic               store, stream_acc, underrun, inject;
   logic               q_ready, q_acc;
   logic [LEN_W-1:0]   len_eff;
   logic               inj_last, inj_err;
   logic [WIDTH-1:0]   cand;

   // Handshakes and strobes are held low while rst is asserted so nothing leaks into the array.
   assign qfull       = (qcnt_q == QCNT_FULL);
   assign stream_open = (state_q == ST_STREAM) && (rcnt_q != len_q);
   assign stream_done = (state_q == ST_STREAM) && (rcnt_q == len_q);
   assign store       = !rst && qfull && bus.r_valid &&
                        ((state_q == ST_IDLE) || (state_q == ST_WAIT) || stream_done);
   assign stream_acc  = !rst && stream_open && bus.r_valid;
   assign underrun    = !rst && stream_open && !bus.r_valid;
   assign inject      = store || stream_acc;
   assign q_ready     = !rst && (qcnt_q < QCNT_FULL) && !store;
   assign q_acc       = q_ready && bus.q_valid;
   assign len_eff     = (bus.ref_len == '0) ? LEN_ONE : bus.ref_len;
   assign inj_last    = store ? (len_eff == LEN_ONE)
                              : (stream_acc && ((rcnt_q + LEN_ONE) == len_q));
   assign inj_err     = stream_acc && err_q;

   always_comb begin
      state_d = state_q;
      qcnt_d  = qcnt_q;
      rcnt_d  = rcnt_q;
      len_d   = len_q;
      err_d   = err_q;
      if (store) begin
         state_d = ST_STREAM;
         qcnt_d  = '0;
         rcnt_d  = LEN_ONE;
         len_d   = len_eff;
         err_d   = 1'b0;
      end else begin
         if (stream_done) state_d = ST_WAIT;
         if (q_acc)       qcnt_d  = qcnt_q + QCNT_ONE;
         if (stream_acc)  rcnt_d  = rcnt_q + LEN_ONE;
         if (underrun)    err_d   = 1'b1;
      end
   end

   // One stage per PE so the tail of the delay line lines up with arr_V of the same column.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_PES; gi++) begin : g_dl
         if (gi == 0) begin : g_head
            assign dl_init_d[gi] = inject;
            assign dl_last_d[gi] = inj_last;
            assign dl_err_d[gi]  = inj_err;
         end else begin : g_tail
            assign dl_init_d[gi] = dl_init_q[gi-1];
            assign dl_last_d[gi] = dl_last_q[gi-1];
            assign dl_err_d[gi]  = dl_err_q[gi-1];
         end
      end
   endgenerate

   assign cand = (bus.arr_V > max_q) ? bus.arr_V : max_q;

   always_comb begin
      max_d         = max_q;
      score_d       = score_q;
      score_valid_d = 1'b0;
      score_err_d   = 1'b0;
      if (dl_init_q[NUM_PES-1]) begin
         if (dl_last_q[NUM_PES-1]) begin
            max_d         = '0;
            score_d       = cand;
            score_valid_d = 1'b1;
            score_err_d   = dl_err_q[NUM_PES-1];
         end else begin
            max_d = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         qcnt_q        <= '0;
         rcnt_q        <= '0;
         len_q         <= '0;
         err_q         <= 1'b0;
         dl_init_q     <= '0;
         dl_last_q     <= '0;
         dl_err_q      <= '0;
         max_q         <= '0;
         score_q       <= '0;
         score_valid_q <= 1'b0;
         score_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         qcnt_q        <= qcnt_d;
         rcnt_q        <= rcnt_d;
         len_q         <= len_d;
         err_q         <= err_d;
         dl_init_q     <= dl_init_d;
         dl_last_q     <= dl_last_d;
         dl_err_q      <= dl_err_d;
         max_q         <= max_d;
         score_q       <= score_d;
         score_valid_q <= score_valid_d;
         score_err_q   <= score_err_d;
      end
   end

   assign bus.q_ready     = q_ready;
   assign bus.r_ready     = store || (!rst && stream_open);
   assign bus.arr_S       = q_acc ? bus.q_base : 2'b00;
   assign bus.arr_shift_S = q_acc;
   assign bus.arr_store_S = store;
   assign bus.arr_T       = inject ? bus.r_base : 2'b00;
   assign bus.arr_init    = inject;
   assign bus.score       = score_q;
   assign bus.score_valid = score_valid_q;
   assign bus.score_err   = score_err_q;
   assign bus.busy        = (state_q != ST_IDLE) || (|dl_init_q);
endmodule
